riscv_load_store_unit: RTL and testbench

Parametrised data-side memory access unit for the RISC-V core, sitting between the core's execute stage and the `IMemoryBus` word-wide memory port. It accepts one load or store request at a time and handles byte, half-word and word sizes. Loads are sign- or zero-extended. Sub-word stores use read-modify-write. Misaligned accesses either raise an error or are split into two word accesses, selected by parameter.

---
 rtl/riscv_load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_load_store_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_load_store_unit.sv
// Data-side load/store unit: one request at a time, byte/half/word accesses over a
// word-wide memory bus, read-modify-write for sub-word stores, optional split of misaligned accesses.
module riscv_load_store_unit #(
    parameter int ADDRESS_SIZE    = 15,
    parameter int MISALIGNED_MODE = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic [1:0]              reqSize,
    input  logic                    reqUnsigned,
    input  logic [ADDRESS_SIZE+1:0] reqAddress,
    input  logic [31:0]             reqData,
    output logic                    respValid,
    output logic                    respError,
    output logic [31:0]             respData,
    output logic [ADDRESS_SIZE-1:0] memAddress,
    output logic                    memWriteEnable,
    output logic                    memStrobe,
    output logic [31:0]             memDataWrite,
    input  logic [31:0]             memDataRead,
    input  logic                    memReady
);

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam bit         SPLIT_ENABLE = (MISALIGNED_MODE == 1);

    typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR1, S_WR2, S_ERR, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic                    r_resp_error;
    logic [31:0]             r_resp_data;
    logic [ADDRESS_SIZE-1:0] r_mem_address;
    logic                    r_mem_write_enable;
    logic                    r_mem_strobe;
    logic [31:0]             r_mem_data_write;
    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [1:0]              r_offset;
    logic [ADDRESS_SIZE-1:0] r_index;
    logic [31:0]             r_data;
    logic                    r_split;
    logic [31:0]             r_word0;
    logic [31:0]             r_word1;

    logic [1:0]              w_in_offset;
    logic                    w_in_misaligned;
    logic                    w_in_split;
    logic                    w_in_error;
    logic                    w_in_word_store;
    logic [ADDRESS_SIZE-1:0] w_index_next;
    logic [4:0]              w_shift;
    logic [31:0]             w_lane_mask;
    logic [63:0]             w_pair;
    logic [63:0]             w_merged;
    logic [31:0]             w_load_word;
    logic [31:0]             w_load_result;

    assign w_in_offset     = reqAddress[1:0];
    assign w_in_misaligned = (reqSize == SIZE_HALF && w_in_offset == 2'd3) ||
                             (reqSize == SIZE_WORD && w_in_offset != 2'd0);
    assign w_in_split      = SPLIT_ENABLE && w_in_misaligned;
    assign w_in_error      = (reqSize == SIZE_ILLEGAL) || (w_in_misaligned && !SPLIT_ENABLE);
    assign w_in_word_store = reqWrite && reqSize == SIZE_WORD && w_in_offset == 2'd0;
    assign w_index_next    = r_index + ADDRESS_SIZE'(1);

    // The word pair {word1, word0} is treated as one 64-bit little-endian window starting at word0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_lane_mask = 32'hFFFF_FFFF;
        case (r_size)
            SIZE_BYTE: w_lane_mask = 32'h0000_00FF;
            SIZE_HALF: w_lane_mask = 32'h0000_FFFF;
            default:   w_lane_mask = 32'hFFFF_FFFF;
        endcase
        w_shift     = {r_offset, 3'b000};
        w_pair      = {r_word1, r_word0};
        w_merged    = (w_pair & ~({32'd0, w_lane_mask} << w_shift)) |
                      ({32'd0, r_data & w_lane_mask} << w_shift);
        w_load_word = 32'(w_pair >> w_shift);
        case (r_size)
            SIZE_BYTE: w_load_result = {{24{!r_unsigned && w_load_word[7]}}, w_load_word[7:0]};
            SIZE_HALF: w_load_result = {{16{!r_unsigned && w_load_word[15]}}, w_load_word[15:0]};
            default:   w_load_result = w_load_word;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_req_ready        <= 1'b0;
            r_resp_valid       <= 1'b0;
            r_resp_error       <= 1'b0;
            r_resp_data        <= 32'd0;
            r_mem_address      <= '0;
            r_mem_write_enable <= 1'b0;
            r_mem_strobe       <= 1'b0;
            r_mem_data_write   <= 32'd0;
            r_write            <= 1'b0;
            r_size             <= SIZE_BYTE;
            r_unsigned         <= 1'b0;
            r_offset           <= 2'd0;
            r_index            <= '0;
            r_data             <= 32'd0;
            r_split            <= 1'b0;
            r_word0            <= 32'd0;
            r_word1            <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_data  <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (reqValid && r_req_ready) begin
                        r_req_ready   <= 1'b0;
                        r_write       <= reqWrite;
                        r_size        <= reqSize;
                        r_unsigned    <= reqUnsigned;
                        r_offset      <= w_in_offset;
                        r_index       <= reqAddress[ADDRESS_SIZE+1:2];
                        r_data        <= reqData;
                        r_split       <= w_in_split;
                        r_word0       <= 32'd0;
                        r_word1       <= 32'd0;
                        r_mem_address <= reqAddress[ADDRESS_SIZE+1:2];
                        if (w_in_error) begin
                            r_state <= S_ERR;
                        end else if (w_in_word_store) begin
                            r_state            <= S_WR1;
                            r_mem_strobe       <= 1'b1;
                            r_mem_write_enable <= 1'b1;
                            r_mem_data_write   <= reqData;
                        end else begin
                            r_state            <= S_RD1;
                            r_mem_strobe       <= 1'b1;
                            r_mem_write_enable <= 1'b0;
                        end
                    end
                end
                // Later accesses launch from a strobe-low cycle, giving the mandatory idle gap on the bus.
                S_RD1, S_RD2: begin
                    if (!r_mem_strobe) begin
                        r_mem_strobe       <= 1'b1;
                        r_mem_write_enable <= 1'b0;
                        r_mem_address      <= (r_state == S_RD1) ? r_index : w_index_next;
                    end else if (memReady) begin
                        r_mem_strobe <= 1'b0;
                        if (r_state == S_RD1) begin
                            r_word0 <= memDataRead;
                        end else begin
                            r_word1 <= memDataRead;
                        end
                        if (r_state == S_RD1 && r_split) begin
                            r_state <= S_RD2;
                        end else begin
                            r_state <= r_write ? S_WR1 : S_DONE;
                        end
                    end
                end
                S_WR1, S_WR2: begin
                    if (!r_mem_strobe) begin
                        r_mem_strobe       <= 1'b1;
                        r_mem_write_enable <= 1'b1;
                        r_mem_address      <= (r_state == S_WR1) ? r_index : w_index_next;
                        r_mem_data_write   <= (r_state == S_WR1) ? w_merged[31:0] : w_merged[63:32];
                    end else if (memReady) begin
                        r_mem_strobe <= 1'b0;
                        r_state      <= (r_state == S_WR1 && r_split) ? S_WR2 : S_DONE;
                    end
                end
                S_ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b1;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_DONE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= r_write ? 32'd0 : w_load_result;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reqReady       = r_req_ready;
    assign respValid      = r_resp_valid;
    assign respError      = r_resp_error;
    assign respData       = r_resp_data;
    assign memAddress     = r_mem_address;
    assign memWriteEnable = r_mem_write_enable;
    assign memStrobe      = r_mem_strobe;
    assign memDataWrite   = r_mem_data_write;

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Bench for riscv_load_store_unit: a default-parameter instance (error mode) and a small split-mode
// instance, each with a wait-state memory model; vector table, corner sequences and random ops vs a byte model.
module tb_riscv_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_unsigned;
    logic [1:0]  req_size;
    logic [16:0] req_addr;
    logic [31:0] req_data;
    bit          sel;
    int          wait_cycles;
    int          checks = 0;
    int          errors = 0;

    logic        ready0, rv0, re0, mwe0, mstb0, mrdy0;
    logic [31:0] rd0, mwd0, mrd0;
    logic [14:0] maddr0;
    logic        ready1, rv1, re1, mwe1, mstb1, mrdy1;
    logic [31:0] rd1, mwd1, mrd1;
    logic [3:0]  maddr1;

    logic        w_ready, w_rv, w_re, w_stb;
    logic [31:0] w_rd;

    logic [31:0] mem0 [0:32767];
    logic [31:0] mem1 [0:15];
    int          wcnt0 = 0;
    int          wcnt1 = 0;
    logic        pre_en;
    bit          pre_sel;
    logic [14:0] pre_addr;
    logic [31:0] pre_data;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [31:0] data;
    } bus_t;
    bus_t log0 [$];

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [16:0] addr;
        logic [31:0] data;
        int          wt;
        bit          e_err;
        logic [31:0] e_data;
        int          e_n;
    } vec_t;
    vec_t vecs [18];

    logic [7:0] ref_bytes [0:63];

    riscv_load_store_unit dut0 (
        .clock(clock), .reset(reset),
        .reqValid(req_valid && !sel), .reqReady(ready0), .reqWrite(req_write),
        .reqSize(req_size), .reqUnsigned(req_unsigned), .reqAddress(req_addr), .reqData(req_data),
        .respValid(rv0), .respError(re0), .respData(rd0),
        .memAddress(maddr0), .memWriteEnable(mwe0), .memStrobe(mstb0), .memDataWrite(mwd0),
        .memDataRead(mrd0), .memReady(mrdy0)
    );

    riscv_load_store_unit #(.ADDRESS_SIZE(4), .MISALIGNED_MODE(1)) dut1 (
        .clock(clock), .reset(reset),
        .reqValid(req_valid && sel), .reqReady(ready1), .reqWrite(req_write),
        .reqSize(req_size), .reqUnsigned(req_unsigned), .reqAddress(req_addr[5:0]), .reqData(req_data),
        .respValid(rv1), .respError(re1), .respData(rd1),
        .memAddress(maddr1), .memWriteEnable(mwe1), .memStrobe(mstb1), .memDataWrite(mwd1),
        .memDataRead(mrd1), .memReady(mrdy1)
    );

    always #5 clock = ~clock;

    assign w_ready = sel ? ready1 : ready0;
    assign w_rv    = sel ? rv1 : rv0;
    assign w_re    = sel ? re1 : re0;
    assign w_rd    = sel ? rd1 : rd0;
    assign w_stb   = sel ? mstb1 : mstb0;

    // Memory model: ready after wait_cycles strobe cycles; reads are combinational from the array.
    assign mrdy0 = mstb0 && (wcnt0 == wait_cycles);
    assign mrdy1 = mstb1 && (wcnt1 == wait_cycles);
    assign mrd0  = mem0[maddr0];
    assign mrd1  = mem1[maddr1];

    always @(posedge clock) begin
        wcnt0 <= (mstb0 && !mrdy0) ? wcnt0 + 1 : 0;
        wcnt1 <= (mstb1 && !mrdy1) ? wcnt1 + 1 : 0;
        if (mstb0 && mrdy0) begin
            if (mwe0) mem0[maddr0] <= mwd0;
            log0.push_back({mwe0, maddr0, mwe0 ? mwd0 : mrd0});
        end
        if (mstb1 && mrdy1 && mwe1) mem1[maddr1] <= mwd1;
        if (pre_en) begin
            if (pre_sel) mem1[pre_addr[3:0]] <= pre_data;
            else         mem0[pre_addr] <= pre_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic preload(input bit s, input logic [14:0] a, input logic [31:0] d);
        pre_sel = s; pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(posedge clock); #1;
        pre_en = 1'b0;
    endtask

    // Issues one request (called #1 after a rising edge) and counts edges from acceptance to respValid.
    task automatic run_op(input bit s, input bit wr, input logic [1:0] sz, input bit u,
                          input logic [16:0] a, input logic [31:0] d, input int w,
                          output bit err, output logic [31:0] data, output int n, output bit stb);
        int guard;
        sel = s; wait_cycles = w; err = 1'b0; data = 32'd0; n = 0; stb = 1'b0; guard = 0;
        while (!w_ready && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        if (!w_ready) begin
            bound_fail("ready_wait");
            return;
        end
        req_write = wr; req_size = sz; req_unsigned = u; req_addr = a; req_data = d; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 17'($urandom); req_data = $urandom;
        while (n < 200) begin
            if (w_stb) stb = 1'b1;
            @(posedge clock); #1; n++;
            if (w_rv) begin
                err = w_re; data = w_rd;
                return;
            end
        end
        bound_fail("resp_wait");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          err, stb, mis;
        logic [31:0] data, d, v, expw;
        int          n, guard, nb, acc, w, log_start;
        logic [1:0]  sz;
        logic [5:0]  a;
        bit          wr, u;
        logic [1:0]  e_o;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        req_size = 2'b00; req_addr = '0; req_data = '0; sel = 1'b0; wait_cycles = 0;
        pre_en = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_reqReady", {31'd0, ready0}, 32'd0);
        check("rst_respValid", {31'd0, rv0}, 32'd0);
        check("rst_respError", {31'd0, re0}, 32'd0);
        check("rst_respData", rd0, 32'd0);
        check("rst_memStrobe", {31'd0, mstb0}, 32'd0);
        check("rst_memWriteEnable", {31'd0, mwe0}, 32'd0);
        check("rst_memAddress", {17'd0, maddr0}, 32'd0);
        check("rst_memDataWrite", mwd0, 32'd0);

        @(negedge clock);
        reset = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, ready0}, 32'd0);
        @(posedge clock); #1;
        check("ready_after_first_edge", {31'd0, ready0}, 32'd1);

        preload(0, 15'd5, 32'h80FF_1234);
        preload(0, 15'd3, 32'hAABB_CCDD);

        //            wr  sz     uns addr      data           wt err e_data         n
        vecs[0]  = '{0, 2'b00, 0, 17'h00017, 32'h0,          0, 0, 32'hFFFF_FF80, 2};
        vecs[1]  = '{0, 2'b00, 1, 17'h00017, 32'h0,          0, 0, 32'h0000_0080, 2};
        vecs[2]  = '{0, 2'b01, 0, 17'h00016, 32'h0,          0, 0, 32'hFFFF_80FF, 2};
        vecs[3]  = '{0, 2'b01, 1, 17'h00014, 32'h0,          0, 0, 32'h0000_1234, 2};
        vecs[4]  = '{0, 2'b01, 0, 17'h00015, 32'h0,          1, 0, 32'hFFFF_FF12, 3};
        vecs[5]  = '{0, 2'b10, 0, 17'h00014, 32'h0,          2, 0, 32'h80FF_1234, 4};
        vecs[6]  = '{0, 2'b10, 0, 17'h00001, 32'h0,          0, 1, 32'h0,         1};
        vecs[7]  = '{0, 2'b01, 0, 17'h00003, 32'h0,          0, 1, 32'h0,         1};
        vecs[8]  = '{0, 2'b11, 0, 17'h00014, 32'h0,          0, 1, 32'h0,         1};
        vecs[9]  = '{1, 2'b11, 0, 17'h00014, 32'h1234_5678,  0, 1, 32'h0,         1};
        vecs[10] = '{1, 2'b10, 0, 17'h00002, 32'h1234_5678,  0, 1, 32'h0,         1};
        vecs[11] = '{1, 2'b10, 0, 17'h00020, 32'hCAFE_F00D,  0, 0, 32'h0,         2};
        vecs[12] = '{0, 2'b10, 0, 17'h00020, 32'h0,          0, 0, 32'hCAFE_F00D, 2};
        vecs[13] = '{0, 2'b00, 1, 17'h00021, 32'h0,          0, 0, 32'h0000_00F0, 2};
        vecs[14] = '{1, 2'b00, 0, 17'h00023, 32'hFFFF_FFA5,  0, 0, 32'h0,         4};
        vecs[15] = '{0, 2'b10, 0, 17'h00020, 32'h0,          0, 0, 32'hA5FE_F00D, 2};
        vecs[16] = '{1, 2'b10, 0, 17'h1FFFC, 32'h0BAD_CAFE,  0, 0, 32'h0,         2};
        vecs[17] = '{0, 2'b10, 0, 17'h1FFFC, 32'h0,          1, 0, 32'h0BAD_CAFE, 3};

        for (int i = 0; i < 18; i++) begin
            run_op(0, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].data, vecs[i].wt,
                   err, data, n, stb);
            check($sformatf("vec%0d_error", i), {31'd0, err}, {31'd0, vecs[i].e_err});
            check($sformatf("vec%0d_data", i), data, vecs[i].e_data);
            check($sformatf("vec%0d_latency", i), n, vecs[i].e_n);
            if (vecs[i].e_err) check($sformatf("vec%0d_no_strobe", i), {31'd0, stb}, 32'd0);
        end
        check("word3_untouched_by_errors", mem0[3], 32'hAABB_CCDD);

        // Sub-word store with one wait state: read word 3, then write the merged word.
        log_start = log0.size();
        run_op(0, 1, 2'b01, 0, 17'h0000E, 32'h0000_1122, 1, err, data, n, stb);
        check("rmw_latency", n, 6);
        check("rmw_error", {31'd0, err}, 32'd0);
        check("rmw_data", data, 32'd0);
        check("rmw_bus_count", log0.size() - log_start, 2);
        if (log0.size() - log_start >= 2) begin
            check("rmw_bus0_we", {31'd0, log0[log_start].we}, 32'd0);
            check("rmw_bus0_addr", {17'd0, log0[log_start].addr}, 32'd3);
            check("rmw_bus1_we", {31'd0, log0[log_start+1].we}, 32'd1);
            check("rmw_bus1_addr", {17'd0, log0[log_start+1].addr}, 32'd3);
            check("rmw_bus1_data", log0[log_start+1].data, 32'h1122_CCDD);
        end
        check("rmw_mem", mem0[3], 32'h1122_CCDD);

        // Split-mode instance: misaligned word access wrapping from word 15 to word 0.
        preload(1, 15'd15, 32'h4433_2211);
        preload(1, 15'd0, 32'h8877_6655);
        run_op(1, 0, 2'b10, 0, 17'h0003E, 32'h0, 0, err, data, n, stb);
        check("split_load_data", data, 32'h6655_4433);
        check("split_load_latency", n, 4);
        check("split_load_error", {31'd0, err}, 32'd0);
        run_op(1, 1, 2'b10, 0, 17'h0003E, 32'hDEAD_BEEF, 0, err, data, n, stb);
        check("split_store_latency", n, 8);
        check("split_store_word15", mem1[15], 32'hBEEF_2211);
        check("split_store_word0", mem1[0], 32'h8877_DEAD);

        // Reset while the write phase of a read-modify-write is on the bus.
        preload(0, 15'd10, 32'h0102_0304);
        sel = 1'b0; wait_cycles = 3;
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 17'h00028;
        req_data = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!(mstb0 && mwe0) && guard < 40) begin
            @(posedge clock); #1; guard++;
        end
        if (!(mstb0 && mwe0)) bound_fail("rst_reach_wr1");
        #2 reset = 1'b0;
        #1;
        check("rst_mid_strobe_drop", {31'd0, mstb0}, 32'd0);
        check("rst_mid_no_resp", {31'd0, rv0}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_mid_mem_unchanged", mem0[10], 32'h0102_0304);
        check("rst_mid_ready_low", {31'd0, ready0}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("rst_mid_ready_before_edge", {31'd0, ready0}, 32'd0);
        @(posedge clock); #1;
        check("rst_mid_ready_after_edge", {31'd0, ready0}, 32'd1);
        check("rst_mid_no_resp_after", {31'd0, rv0}, 32'd0);

        // Back-to-back loads: the second is accepted in the respValid cycle of the first.
        sel = 1'b0; wait_cycles = 0;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 17'h00014; req_valid = 1'b1;
        @(posedge clock); #1;
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 17'h00017;
        n = 0;
        while (!rv0 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check("b2b_first_latency", n, 2);
        check("b2b_first_data", rd0, 32'h80FF_1234);
        check("b2b_ready_in_resp_cycle", {31'd0, ready0}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("b2b_second_accepted", {31'd0, ready0}, 32'd0);
        n = 0;
        while (!rv0 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check("b2b_second_latency", n, 2);
        check("b2b_second_data", rd0, 32'h0000_0080);

        // Random traffic on the split-mode instance against a byte-addressed reference memory.
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            preload(1, 15'(k), d);
            for (int b = 0; b < 4; b++) ref_bytes[4*k+b] = d[8*b +: 8];
        end
        for (int t = 0; t < 150; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = 6'($urandom_range(0, 63));
            wr = 1'($urandom); u = 1'($urandom); d = $urandom; w = $urandom_range(0, 2);
            e_o = a[1:0];
            v = 32'd0;
            acc = 0;
            if (sz != 2'b11) begin
                nb = 1 << sz;
                mis = (sz == 2'b01 && e_o == 2'd3) || (sz == 2'b10 && e_o != 2'd0);
                if (!wr) begin
                    for (int b = 0; b < nb; b++) v = v | (32'(ref_bytes[(int'(a) + b) % 64]) << (8 * b));
                    if (!u && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
                    if (!u && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
                    acc = mis ? 2 : 1;
                end else begin
                    for (int b = 0; b < nb; b++) ref_bytes[(int'(a) + b) % 64] = d[8*b +: 8];
                    acc = (sz == 2'b10 && !mis) ? 1 : (mis ? 4 : 2);
                end
            end
            run_op(1, wr, sz, u, {11'd0, a}, d, w, err, data, n, stb);
            check($sformatf("rnd%0d_error", t), {31'd0, err}, {31'd0, sz == 2'b11});
            check($sformatf("rnd%0d_data", t), data, v);
            check($sformatf("rnd%0d_latency", t), n, (sz == 2'b11) ? 1 : acc * (2 + w));
            for (int k = 0; k < 16; k++) begin
                expw = {ref_bytes[4*k+3], ref_bytes[4*k+2], ref_bytes[4*k+1], ref_bytes[4*k]};
                check($sformatf("rnd%0d_mem%0d", t, k), mem1[k], expw);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
